// File: rtl/pr_free_list.sv
// Banked physical-register free list: one circular FIFO of PR upper bits per PRF bank.
// Define PR_FREE_LIST_BYPASS_EN to let an empty bank hand a freed PR straight to rename.
module pr_free_list #(
    parameter int PR_COUNT = 128,
    parameter int FREE_LIST_BANK_COUNT = 4,
    parameter int FREE_LIST_LENGTH_PER_BANK = 32,
    parameter int FREE_LIST_LOWER_THRESHOLD = 8,
    parameter int FREE_LIST_UPPER_THRESHOLD = 24,
    localparam int NB = FREE_LIST_BANK_COUNT,
    localparam int LEN = FREE_LIST_LENGTH_PER_BANK,
    localparam int BW = $clog2(NB),
    localparam int PW = $clog2(LEN),
    localparam int UW = $clog2(PR_COUNT / NB),
    localparam int CW = PW + 1
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [NB-1:0]            enq_valid_by_bank,
    input  logic [NB-1:0][UW-1:0]    enq_upper_PR_by_bank,
    output logic [NB-1:0]            deq_valid_by_bank,
    output logic [NB-1:0][UW+BW-1:0] deq_PR_by_bank,
    input  logic [NB-1:0]            deq_ready_by_bank,
    output logic [NB-1:0][CW-1:0]    count_by_bank,
    output logic [NB-1:0]            below_lower_by_bank,
    output logic [NB-1:0]            above_upper_by_bank,
    output logic                     overflow_err
);

    logic [NB-1:0] err_set;

    for (genvar b = 0; b < NB; b++) begin : g_bank
        logic [LEN-1:0][UW-1:0] mem;
        logic [PW-1:0]          head;
        logic [PW-1:0]          tail;
        logic [CW-1:0]          count;
        logic                   nonempty;
        logic                   full;
        logic                   pop;
        logic                   push;
        logic                   bypass;
        logic                   take;

        assign nonempty = (count != '0);
        assign full     = (count == CW'(LEN));
        assign pop      = nonempty & deq_ready_by_bank[b];

`ifdef PR_FREE_LIST_BYPASS_EN
        assign bypass = ~nonempty & enq_valid_by_bank[b];
`else
        assign bypass = 1'b0;
`endif

        // A bypassed PR taken by rename never touches storage.
        assign take = bypass & deq_ready_by_bank[b];
        assign push = enq_valid_by_bank[b] & (~full | pop) & ~take;

        assign err_set[b] = enq_valid_by_bank[b] & full & ~pop;

        assign deq_valid_by_bank[b] = nonempty | bypass;
        assign deq_PR_by_bank[b] = {
            bypass ? enq_upper_PR_by_bank[b] : mem[head],
            BW'(b)
        };

        assign count_by_bank[b] = count;
        assign below_lower_by_bank[b] =
            (count < CW'(FREE_LIST_LOWER_THRESHOLD));
        assign above_upper_by_bank[b] =
            (count > CW'(FREE_LIST_UPPER_THRESHOLD));

        // Upper half of the PR space starts free; lower half is mapped.
        always_ff @(posedge CLK) begin
            if (!nRST) begin
                for (int i = 0; i < LEN; i++) begin
                    mem[i] <= (i < LEN / 2) ? UW'(LEN / 2 + i) : '0;
                end
                head  <= '0;
                tail  <= PW'(LEN / 2);
                count <= CW'(LEN / 2);
            end else begin
                if (push) begin
                    mem[tail] <= enq_upper_PR_by_bank[b];
                    tail      <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push & ~pop) begin
                    count <= count + CW'(1);
                end else if (pop & ~push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            overflow_err <= 1'b0;
        end else if (|err_set) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pr_free_list.sv
// Self-checking bench for pr_free_list: directed scenarios plus
// randomized traffic against a queue-per-bank reference model.
module tb_pr_free_list;

`ifdef PR_FREE_LIST_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic             clk;
    logic             nrst;
    logic [3:0]       enq_valid;
    logic [3:0][4:0]  enq_upper;
    logic [3:0]       deq_valid;
    logic [3:0][6:0]  deq_pr;
    logic [3:0]       deq_ready;
    logic [3:0][5:0]  count;
    logic [3:0]       below;
    logic [3:0]       above;
    logic             ovf;

    int checks = 0;
    int passes = 0;

    typedef logic [6:0] pr_q_t[$];
    pr_q_t q[4];
    logic m_ovf;

    logic [3:0]      e_valid;
    logic [3:0][6:0] e_pr;
    logic [3:0][5:0] e_count;
    logic [3:0]      e_below;
    logic [3:0]      e_above;

    pr_free_list dut (
        .CLK                  (clk),
        .nRST                 (nrst),
        .enq_valid_by_bank    (enq_valid),
        .enq_upper_PR_by_bank (enq_upper),
        .deq_valid_by_bank    (deq_valid),
        .deq_PR_by_bank       (deq_pr),
        .deq_ready_by_bank    (deq_ready),
        .count_by_bank        (count),
        .below_lower_by_bank  (below),
        .above_upper_by_bank  (above),
        .overflow_err         (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Free list after reset holds PR 64..127, bank = PR % 4, in ascending order.
    task automatic model_reset();
        for (int b = 0; b < 4; b++) begin
            q[b].delete();
            for (int p = 64; p < 128; p++) begin
                if (p % 4 == b) q[b].push_back(7'(p));
            end
        end
        m_ovf = 1'b0;
    endtask

    task automatic model_outputs();
        for (int b = 0; b < 4; b++) begin
            int n;
            n = q[b].size();
            e_valid[b] = (n != 0) || (BYP && enq_valid[b]);
            e_pr[b] = (n != 0) ? q[b][0] : 7'(enq_upper[b] * 4 + b);
            e_count[b] = 6'(n);
            e_below[b] = (n < 8);
            e_above[b] = (n > 24);
        end
    endtask

    task automatic model_apply();
        for (int b = 0; b < 4; b++) begin
            int n;
            bit pop;
            bit take;
            n = q[b].size();
            pop = (n != 0) && deq_ready[b];
            take = BYP && (n == 0) && enq_valid[b] && deq_ready[b];
            if (!take) begin
                if (pop) void'(q[b].pop_front());
                if (enq_valid[b]) begin
                    if (n == 32 && !pop) m_ovf = 1'b1;
                    else q[b].push_back(7'(enq_upper[b] * 4 + b));
                end
            end
        end
    endtask

    task automatic tick();
        model_apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        enq_valid = '0;
        enq_upper = '0;
        deq_ready = '0;
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        enq_valid = 4'($urandom);
        enq_upper = 20'($urandom);
        deq_ready = 4'($urandom);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        idle_inputs();
        model_reset();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (deq_valid !== 4'hf)
            $display("FAIL reset_valid: got %b want 1111", deq_valid);
        else passes++;
        checks++;
        if (deq_pr !== {7'd67, 7'd66, 7'd65, 7'd64})
            $display("FAIL reset_pr: got %h want 64..67", deq_pr);
        else passes++;
        checks++;
        if (count !== {6'd16, 6'd16, 6'd16, 6'd16})
            $display("FAIL reset_count: got %h want 16 x4", count);
        else passes++;
        checks++;
        if ({below, above, ovf} !== 9'd0)
            $display("FAIL reset_flags: got %b want 0", {below, above, ovf});
        else passes++;
    endtask

    task automatic test_drain_bank2();
        do_reset();
        deq_ready = 4'b0100;
        for (int k = 0; k < 16; k++) begin
            #1;
            checks++;
            if (deq_pr[2] !== 7'(66 + 4 * k))
                $display("FAIL drain_pr: pop %0d got %0d want %0d",
                         k, deq_pr[2], 66 + 4 * k);
            else passes++;
            checks++;
            if (count[2] !== 6'(16 - k) || below[2] !== (16 - k < 8))
                $display("FAIL drain_count: pop %0d got %0d/%b want %0d",
                         k, count[2], below[2], 16 - k);
            else passes++;
            tick();
        end
        deq_ready = '0;
        #1;
        checks++;
        if (count[2] !== 6'd0 || deq_valid[2] !== 1'b0 || below[2] !== 1'b1)
            $display("FAIL drain_empty: got cnt %0d v %b lo %b want 0 0 1",
                     count[2], deq_valid[2], below[2]);
        else passes++;
    endtask

    task automatic test_push_empty();
        do_reset();
        deq_ready = 4'b0010;
        for (int k = 0; k < 16; k++) tick();
        deq_ready = '0;
        enq_valid = 4'b0010;
        enq_upper[1] = 5'd3;
        #1;
`ifndef PR_FREE_LIST_BYPASS_EN
        checks++;
        if (deq_valid[1] !== 1'b0)
            $display("FAIL push_empty_same: got %b want 0", deq_valid[1]);
        else passes++;
`endif
        tick();
        enq_upper[1] = 5'd9;
        #1;
        checks++;
        if (deq_valid[1] !== 1'b1 || deq_pr[1] !== 7'd13)
            $display("FAIL push_empty_next: got %b/%0d want 1/13",
                     deq_valid[1], deq_pr[1]);
        else passes++;
        tick();
        idle_inputs();
        deq_ready = 4'b0010;
        #1;
        checks++;
        if (deq_pr[1] !== 7'd13)
            $display("FAIL push_pop1: got %0d want 13", deq_pr[1]);
        else passes++;
        tick();
        checks++;
        if (deq_pr[1] !== 7'd37 || deq_valid[1] !== 1'b1)
            $display("FAIL push_pop2: got %0d want 37", deq_pr[1]);
        else passes++;
        tick();
        deq_ready = '0;
        #1;
        checks++;
        if (count[1] !== 6'd0 || deq_valid[1] !== 1'b0)
            $display("FAIL push_final: got cnt %0d v %b want 0 0",
                     count[1], deq_valid[1]);
        else passes++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        enq_valid = 4'b0001;
        for (int k = 0; k < 16; k++) begin
            enq_upper[0] = 5'(k);
            #1;
            checks++;
            if (count[0] !== 6'(16 + k) || above[0] !== (16 + k > 24))
                $display("FAIL fill_count: push %0d got %0d/%b want %0d",
                         k, count[0], above[0], 16 + k);
            else passes++;
            tick();
        end
        checks++;
        if (count[0] !== 6'd32 || above[0] !== 1'b1 || ovf !== 1'b0)
            $display("FAIL fill_full: got %0d/%b/%b want 32/1/0",
                     count[0], above[0], ovf);
        else passes++;
        enq_upper[0] = 5'd31;
        deq_ready = 4'b0001;
        #1;
        checks++;
        if (deq_pr[0] !== 7'd64)
            $display("FAIL full_swap_pr: got %0d want 64", deq_pr[0]);
        else passes++;
        tick();
        checks++;
        if (count[0] !== 6'd32 || ovf !== 1'b0)
            $display("FAIL full_swap: got %0d/%b want 32/0", count[0], ovf);
        else passes++;
        deq_ready = '0;
        tick();
        enq_valid = '0;
        #1;
        checks++;
        if (ovf !== 1'b1 || count[0] !== 6'd32 || deq_pr[0] !== 7'd68)
            $display("FAIL overflow: got %b/%0d/%0d want 1/32/68",
                     ovf, count[0], deq_pr[0]);
        else passes++;
        do_reset();
        checks++;
        if (ovf !== 1'b0)
            $display("FAIL overflow_clear: got %b want 0", ovf);
        else passes++;
    endtask

    task automatic test_wrap();
        logic [4:0] pushed[40];
        do_reset();
        enq_valid = 4'b1000;
        deq_ready = 4'b1000;
        for (int k = 0; k < 40; k++) begin
            logic [6:0] want;
            pushed[k] = 5'($urandom);
            enq_upper[3] = pushed[k];
            want = (k < 16) ? 7'(67 + 4 * k) : {pushed[k - 16], 2'd3};
            #1;
            checks++;
            if (deq_pr[3] !== want || count[3] !== 6'd16)
                $display("FAIL wrap: step %0d got %0d/%0d want %0d/16",
                         k, deq_pr[3], count[3], want);
            else passes++;
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc == 200) begin
                do_reset();
                checks++;
                if (count !== {6'd16, 6'd16, 6'd16, 6'd16} || ovf !== 1'b0
                    || deq_pr !== {7'd67, 7'd66, 7'd65, 7'd64})
                    $display("FAIL mid_reset: got %h/%b/%h", count, ovf, deq_pr);
                else passes++;
            end
            enq_valid = 4'($urandom);
            enq_upper = 20'($urandom);
            deq_ready = 4'($urandom);
            #1;
            model_outputs();
            checks++;
            if (deq_valid !== e_valid || count !== e_count)
                $display("FAIL rand_state: cyc %0d got %b/%h want %b/%h",
                         cyc, deq_valid, count, e_valid, e_count);
            else passes++;
            checks++;
            if (below !== e_below || above !== e_above || ovf !== m_ovf)
                $display("FAIL rand_flags: cyc %0d got %b/%b/%b want %b/%b/%b",
                         cyc, below, above, ovf, e_below, e_above, m_ovf);
            else passes++;
            for (int b = 0; b < 4; b++) begin
                if (e_valid[b]) begin
                    checks++;
                    if (deq_pr[b] !== e_pr[b])
                        $display("FAIL rand_pr: cyc %0d bank %0d got %0d want %0d",
                                 cyc, b, deq_pr[b], e_pr[b]);
                    else passes++;
                end
            end
            tick();
        end
        idle_inputs();
    endtask

`ifdef PR_FREE_LIST_BYPASS_EN
    task automatic test_bypass();
        do_reset();
        deq_ready = 4'b0010;
        for (int k = 0; k < 16; k++) tick();
        enq_valid = 4'b0010;
        enq_upper[1] = 5'd5;
        #1;
        checks++;
        if (deq_valid[1] !== 1'b1 || deq_pr[1] !== 7'd21)
            $display("FAIL bypass_pr: got %b/%0d want 1/21",
                     deq_valid[1], deq_pr[1]);
        else passes++;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (count[1] !== 6'd0 || deq_valid[1] !== 1'b0)
            $display("FAIL bypass_count: got %0d/%b want 0/0",
                     count[1], deq_valid[1]);
        else passes++;
    endtask
`endif

    initial begin
        nrst = 1'b0;
        idle_inputs();
        test_reset();
        test_drain_bank2();
        test_push_empty();
        test_fill_overflow();
        test_wrap();
        test_random();
`ifdef PR_FREE_LIST_BYPASS_EN
        test_bypass();
`endif
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
